// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family: read-mode encoding and
// width helpers used to size counters at elaboration time.
package fifo_pkg;

  typedef enum logic {
    FIFO_RD_REG  = 1'b0,
    FIFO_RD_FWFT = 1'b1
  } fifo_rd_mode_e;

  // A fill counter must represent 0..depth inclusive, hence depth+1 states.
  function automatic int fifo_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Modulo-DEPTH pointer for FIFO storage; DEPTH need not be a power of two,
// so the wrap is an explicit compare rather than natural binary overflow.
module fifo_ptr_wrap #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_ptr
);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ptr <= '0;
    end else if (i_inc) begin
      if (o_ptr == WIDTH'(DEPTH - 1)) begin
        o_ptr <= '0;
      end else begin
        o_ptr <= o_ptr + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/fifo_sync_flag.sv
// Single-clock FIFO with arbitrary depth, registered or FWFT read, fill count,
// programmable almost-full/almost-empty thresholds and sticky error flags.
module fifo_sync_flag
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int PTRS_WIDTH = $clog2(FIFO_DEPTH),
  parameter int CNT_WIDTH  = fifo_cnt_width(FIFO_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_full,
  output logic                  o_almost_full,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_empty,
  output logic                  o_almost_empty,
  output logic [CNT_WIDTH-1:0]  o_cnt,
  input  logic                  i_clr_err,
  output logic                  o_ovf,
  output logic                  o_udf
);

  localparam fifo_rd_mode_e RD_MODE = (FWFT != 0) ? FIFO_RD_FWFT : FIFO_RD_REG;

  if (FIFO_DEPTH < 2 || AF_LEVEL > FIFO_DEPTH || AE_LEVEL >= FIFO_DEPTH) begin : g_param_err
    $error("fifo_sync_flag: illegal FIFO_DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTRS_WIDTH-1:0] wr_ptr;
  logic [PTRS_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ovf_q;
  logic                  udf_q;

  // Acceptance is judged against the flags held before the edge, so a full
  // FIFO rejects a same-cycle write even though a read frees a slot.
  assign wr_acc = i_wr_en & ~o_wr_full;
  assign rd_acc = i_rd_en & ~o_rd_empty;

  fifo_ptr_wrap #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PTRS_WIDTH)
  ) u_wr_ptr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (wr_acc),
    .o_ptr (wr_ptr)
  );

  fifo_ptr_wrap #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PTRS_WIDTH)
  ) u_rd_ptr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (rd_acc),
    .o_ptr (rd_ptr)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   cnt_q <= cnt_q + CNT_WIDTH'(1);
        2'b01:   cnt_q <= cnt_q - CNT_WIDTH'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage carries no reset; stale entries are never visible past the count.
  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= i_wr_data;
    end
  end

  // Error flags are sticky; a new violation in the clearing cycle wins.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (i_wr_en && o_wr_full) begin
        ovf_q <= 1'b1;
      end else if (i_clr_err) begin
        ovf_q <= 1'b0;
      end
      if (i_rd_en && o_rd_empty) begin
        udf_q <= 1'b1;
      end else if (i_clr_err) begin
        udf_q <= 1'b0;
      end
    end
  end

  if (RD_MODE == FIFO_RD_FWFT) begin : g_rd_fwft
    assign o_rd_data = mem[rd_ptr];
  end else begin : g_rd_reg
    logic [DATA_WIDTH-1:0] rd_data_q;
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        rd_data_q <= '0;
      end else if (rd_acc) begin
        rd_data_q <= mem[rd_ptr];
      end
    end
    assign o_rd_data = rd_data_q;
  end

  assign o_cnt          = cnt_q;
  assign o_wr_full      = (int'(cnt_q) == FIFO_DEPTH);
  assign o_rd_empty     = (cnt_q == '0);
  assign o_almost_full  = (int'(cnt_q) >= AF_LEVEL);
  assign o_almost_empty = (int'(cnt_q) <= AE_LEVEL);
  assign o_ovf          = ovf_q;
  assign o_udf          = udf_q;

endmodule

// File: tb/tb_fifo_sync_flag.sv
// Bench for fifo_sync_flag: a depth-8 registered-read instance and a depth-5
// FWFT instance share stimulus and are checked against queue-based models.
module tb_fifo_sync_flag;

  localparam int DW  = 32;
  localparam int DA  = 8;
  localparam int AFA = 7;
  localparam int AEA = 1;
  localparam int DB  = 5;
  localparam int AFB = 4;
  localparam int AEB = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic          clr_err;

  logic          a_full, a_afull, a_empty, a_aempty, a_ovf, a_udf;
  logic [DW-1:0] a_rd_data;
  logic [3:0]    a_cnt;
  logic          b_full, b_afull, b_empty, b_aempty, b_ovf, b_udf;
  logic [DW-1:0] b_rd_data;
  logic [2:0]    b_cnt;

  always #5 clk = ~clk;

  fifo_sync_flag #(
    .DATA_WIDTH (DW), .FIFO_DEPTH (DA), .FWFT (0), .AF_LEVEL (AFA), .AE_LEVEL (AEA)
  ) u_dut_a (
    .i_clk (clk), .i_rst (rst),
    .i_wr_en (wr_en), .i_wr_data (wr_data), .o_wr_full (a_full), .o_almost_full (a_afull),
    .i_rd_en (rd_en), .o_rd_data (a_rd_data), .o_rd_empty (a_empty), .o_almost_empty (a_aempty),
    .o_cnt (a_cnt), .i_clr_err (clr_err), .o_ovf (a_ovf), .o_udf (a_udf)
  );

  fifo_sync_flag #(
    .DATA_WIDTH (DW), .FIFO_DEPTH (DB), .FWFT (1), .AF_LEVEL (AFB), .AE_LEVEL (AEB)
  ) u_dut_b (
    .i_clk (clk), .i_rst (rst),
    .i_wr_en (wr_en), .i_wr_data (wr_data), .o_wr_full (b_full), .o_almost_full (b_afull),
    .i_rd_en (rd_en), .o_rd_data (b_rd_data), .o_rd_empty (b_empty), .o_almost_empty (b_aempty),
    .o_cnt (b_cnt), .i_clr_err (clr_err), .o_ovf (b_ovf), .o_udf (b_udf)
  );

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  logic          m_ovf_a, m_udf_a, m_ovf_b, m_udf_b;
  logic [DW-1:0] m_rd_a;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_ovf_a = 1'b0; m_udf_a = 1'b0;
    m_ovf_b = 1'b0; m_udf_b = 1'b0;
    m_rd_a  = '0;
  endtask

  // One clock of FIFO behaviour, judged on occupancy before the edge.
  task automatic model_edge(input logic wr, input logic [DW-1:0] d, input logic rd, input logic clr);
    bit full_a, empty_a, full_b, empty_b;
    full_a  = (qa.size() == DA);
    empty_a = (qa.size() == 0);
    full_b  = (qb.size() == DB);
    empty_b = (qb.size() == 0);
    if (rd && !empty_a) m_rd_a = qa.pop_front();
    if (wr && !full_a)  qa.push_back(d);
    if (rd && !empty_b) void'(qb.pop_front());
    if (wr && !full_b)  qb.push_back(d);
    if (wr && full_a) m_ovf_a = 1'b1; else if (clr) m_ovf_a = 1'b0;
    if (rd && empty_a) m_udf_a = 1'b1; else if (clr) m_udf_a = 1'b0;
    if (wr && full_b) m_ovf_b = 1'b1; else if (clr) m_ovf_b = 1'b0;
    if (rd && empty_b) m_udf_b = 1'b1; else if (clr) m_udf_b = 1'b0;
  endtask

  task automatic check_all(input string ph);
    chk({ph, ":a_cnt"},    32'(a_cnt),    32'(qa.size()));
    chk({ph, ":a_full"},   32'(a_full),   32'(qa.size() == DA));
    chk({ph, ":a_empty"},  32'(a_empty),  32'(qa.size() == 0));
    chk({ph, ":a_afull"},  32'(a_afull),  32'(qa.size() >= AFA));
    chk({ph, ":a_aempty"}, 32'(a_aempty), 32'(qa.size() <= AEA));
    chk({ph, ":a_ovf"},    32'(a_ovf),    32'(m_ovf_a));
    chk({ph, ":a_udf"},    32'(a_udf),    32'(m_udf_a));
    chk({ph, ":a_data"},   a_rd_data,     m_rd_a);
    chk({ph, ":b_cnt"},    32'(b_cnt),    32'(qb.size()));
    chk({ph, ":b_full"},   32'(b_full),   32'(qb.size() == DB));
    chk({ph, ":b_empty"},  32'(b_empty),  32'(qb.size() == 0));
    chk({ph, ":b_afull"},  32'(b_afull),  32'(qb.size() >= AFB));
    chk({ph, ":b_aempty"}, 32'(b_aempty), 32'(qb.size() <= AEB));
    chk({ph, ":b_ovf"},    32'(b_ovf),    32'(m_ovf_b));
    chk({ph, ":b_udf"},    32'(b_udf),    32'(m_udf_b));
    if (qb.size() != 0) chk({ph, ":b_data"}, b_rd_data, qb[0]);
  endtask

  // Called at posedge+1; inputs settle, model advances, outputs checked at next posedge+1.
  task automatic step(input string ph, input logic wr, input logic [DW-1:0] d,
                      input logic rd, input logic clr);
    wr_en = wr; wr_data = d; rd_en = rd; clr_err = clr;
    model_edge(wr, d, rd, clr);
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic do_reset(input string ph);
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
    rst = 1'b1;
    #1;
    model_reset();
    check_all(ph);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    for (int i = 0; i < 9; i++) step("fill", 1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
    chk("fill_ovf", 32'(a_ovf), 32'd1);
    chk("fill_cnt", 32'(a_cnt), 32'd8);
    step("clr", 1'b0, '0, 1'b0, 1'b1);

    for (int i = 0; i < 9; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
    chk("drain_hold", a_rd_data, 32'hA7);
    chk("drain_udf",  32'(a_udf), 32'd1);
    step("udf_setclr", 1'b0, '0, 1'b1, 1'b1);
    chk("udf_set_wins", 32'(a_udf), 32'd1);
    step("clr2", 1'b0, '0, 1'b0, 1'b1);

    for (int i = 0; i < 3; i++) step("pre3", 1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step("rdwr3", 1'b1, $urandom, 1'b1, 1'b0);
    chk("rdwr3_cnt", 32'(a_cnt), 32'd3);

    for (int i = 0; i < 5; i++) step("tofull", 1'b1, $urandom, 1'b0, 1'b0);
    step("clr3", 1'b0, '0, 1'b0, 1'b1);
    step("ovf_setclr", 1'b1, $urandom, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(a_ovf), 32'd1);
    step("clr4", 1'b0, '0, 1'b0, 1'b1);
    step("rdwr_full", 1'b1, $urandom, 1'b1, 1'b0);
    chk("rdwr_full_cnt", 32'(a_cnt), 32'd7);
    chk("rdwr_full_ovf", 32'(a_ovf), 32'd1);

    for (int i = 0; i < 7; i++) step("toempty", 1'b0, '0, 1'b1, 1'b0);
    step("clr5", 1'b0, '0, 1'b0, 1'b1);
    step("rdwr_empty", 1'b1, 32'h77, 1'b1, 1'b0);
    chk("rdwr_empty_cnt", 32'(a_cnt), 32'd1);
    chk("rdwr_empty_udf", 32'(a_udf), 32'd1);

    do_reset("rst_b");
    step("fwft", 1'b1, 32'h55, 1'b0, 1'b0);
    chk("fwft_data",  b_rd_data, 32'h55);
    chk("fwft_empty", 32'(b_empty), 32'd0);

    for (int i = 0; i < 400; i++) begin
      int pw;
      pw = (i / 100) % 2 == 0 ? 70 : 30;
      step("rand", ($urandom_range(0, 99) < pw), $urandom, ($urandom_range(0, 99) < 50),
           ($urandom_range(0, 15) == 0));
    end

    do_reset("rst_c");
    for (int i = 0; i < 4; i++) step("pre4", 1'b1, $urandom, 1'b0, 1'b0);
    chk("pre4_cnt", 32'(a_cnt), 32'd4);
    #2;
    do_reset("async_rst");
    chk("async_rst_cnt", 32'(a_cnt), 32'd0);
    step("post_rst_wr", 1'b1, 32'hC3, 1'b0, 1'b0);
    step("post_rst_rd", 1'b0, '0, 1'b1, 1'b0);
    chk("post_rst_data", a_rd_data, 32'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_sync_flag.md
# fifo_sync_flag

Parametrised single-clock FIFO. It extends the plain synchronous FIFO with arbitrary (non-power-of-two) depth, a selectable read mode (registered or first-word-fall-through), a live fill count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. It sits between producer and consumer stages in the same clock domain and is the default buffering element for new datapaths.

## Interface
- DATA_WIDTH, 32, payload width in bits
- FIFO_DEPTH, 8, number of entries; any value ≥ 2
- FWFT, 0, read mode: 0 = registered read data, 1 = first-word-fall-through
- AF_LEVEL, FIFO_DEPTH-1, o_almost_full asserts when count ≥ AF_LEVEL
- AE_LEVEL, 1, o_almost_empty asserts when count ≤ AE_LEVEL
- PTRS_WIDTH, $clog2(FIFO_DEPTH), pointer width (derived)
- CNT_WIDTH, $clog2(FIFO_DEPTH+1), count width (derived)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset; one clock; reset is asynchronous and active-high
- i_wr_en  in  1  write request
- i_wr_data  in  DATA_WIDTH  write payload
- o_wr_full  out  1  count == FIFO_DEPTH
- o_almost_full  out  1  count ≥ AF_LEVEL
- i_rd_en  in  1  read request
- o_rd_data  out  DATA_WIDTH  read payload
- o_rd_empty  out  1  count == 0
- o_almost_empty  out  1  count ≤ AE_LEVEL
- o_cnt  out  CNT_WIDTH  current fill level
- i_clr_err  in  1  synchronous clear of the sticky error flags
- o_ovf  out  1  sticky: a write was attempted while full
- o_udf  out  1  sticky: a read was attempted while empty

## Operation
- Accepted write: wr_acc = i_wr_en & !o_wr_full. Accepted read: rd_acc = i_rd_en & !o_rd_empty. Both use the flag values from before the clock edge.
- Write pointer and read pointer each advance by 1 on accept and wrap from FIFO_DEPTH-1 to 0. Depth is not assumed to be a power of two.
- Count: +1 on wr_acc only, −1 on rd_acc only, unchanged when both or neither accept. Simultaneous read and write must leave the count unchanged.
- Full with rd+wr in the same cycle: the read is accepted, the write is rejected, and o_ovf is set.
- Empty with rd+wr in the same cycle: the write is accepted, the read is rejected, and o_udf is set.
- o_ovf is set by i_wr_en & o_wr_full. o_udf is set by i_rd_en & o_rd_empty. Both flags hold until i_clr_err. If set and clear happen in the same cycle, set wins.
- FWFT=0: o_rd_data is loaded with mem[rd_ptr] on rd_acc and holds otherwise.
- FWFT=1: o_rd_data = mem[rd_ptr] combinationally. It is valid whenever !o_rd_empty. i_rd_en acts as a pop/acknowledge.
- Storage is not reset; only pointers, count, flags and the o_rd_data register are reset.
- Elaboration error if AF_LEVEL > FIFO_DEPTH, AE_LEVEL ≥ FIFO_DEPTH, or FIFO_DEPTH < 2.

## Timing
- Reset values: o_cnt=0, o_rd_empty=1, o_wr_full=0, o_almost_empty=1, o_almost_full=(AF_LEVEL==0), o_ovf=0, o_udf=0, o_rd_data=0.
- Reset asserted mid-operation discards the contents immediately (asynchronously). The first write is accepted on the first edge after i_rst deasserts.
- All flags and o_cnt are decoded from the registered count. They update on the edge after the accepting cycle.
- Write-to-read latency:
  - FWFT=1: the word is visible on o_rd_data, with o_rd_empty low, 1 cycle after the write edge.
  - FWFT=0: o_rd_data updates on the edge that accepts the read.
- Back-to-back reads and writes are supported every cycle at full throughput.

## Structure
- Shared package fifo_pkg: fifo_rd_mode_e {FIFO_RD_REG, FIFO_RD_FWFT}, and a width helper function for CNT_WIDTH.
- Sub-module fifo_ptr_wrap:
  - parameters DEPTH and WIDTH; ports i_clk, i_rst, i_inc; output o_ptr.
  - wrapping pointer with async active-high reset.
  - instantiated twice, once per pointer.
- Counter, flags and storage array live in fifo_sync_flag.

## Test plan
- Reset, then write 0xA0..0xA7 with FIFO_DEPTH=8 → o_cnt steps 1..8; o_almost_full high at cnt 7; o_wr_full high after the 8th write; 9th write gives o_ovf=1 and cnt stays 8.
- Drain a full FIFO (FWFT=0) → o_rd_data sequence 0xA0..0xA7; o_rd_empty high after the 8th read; an extra read sets o_udf=1 and o_rd_data holds 0xA7.
- FIFO_DEPTH=5: 12 writes interleaved with reads → data order preserved across pointer wrap (4→0); o_cnt never exceeds 5.
- Simultaneous rd+wr at cnt 3 for 10 cycles → cnt stays 3; at full, rd+wr gives cnt 7 and o_ovf=1; at empty, rd+wr gives cnt 1 and o_udf=1.
- FWFT=1: write 0x55 to an empty FIFO → o_rd_data=0x55 and o_rd_empty=0 one cycle later, with no read issued.
- Assert i_rst while cnt=4 → all outputs return to reset values without a clock edge; i_clr_err pulse clears o_ovf/o_udf; simultaneous set and clear leaves the flag set.
